emu_axi_ram_backend: RTL and testbench
======================================

Name: emu_axi_ram_backend

Overview:
- AXI4 slave memory model that sits directly downstream of the emulated DUT's `m_axi` DRAM master port in the rammodel test harness.
- Serves write and read bursts from an internal word array, with a programmable read latency, so the bench can run the DUT without an external memory model.
- Handles one transaction at a time, write or read, which keeps response ordering trivially in-order per ID.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width; a power of two, at least 8.
- ID_WIDTH, 4, AXI ID width.
- MEM_WORDS_LOG2, 16, log2 of the number of DATA_WIDTH-bit words in the array.
- READ_LATENCY, 4, cycles from the AR handshake to the first `rvalid`; valid range 1..255.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- s_axi_awvalid/awready/awaddr/awid/awlen/awsize/awburst  in/out/in/in/in/in/in  1/1/ADDR_WIDTH/ID_WIDTH/8/3/2  AW channel.
- s_axi_wvalid/wready/wdata/wstrb/wlast  in/out/in/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8/1  W channel.
- s_axi_bvalid/bready/bresp/bid  out/in/out/out  1/1/2/ID_WIDTH  B channel.
- s_axi_arvalid/arready/araddr/arid/arlen/arsize/arburst  in/out/in/in/in/in/in  1/1/ADDR_WIDTH/ID_WIDTH/8/3/2  AR channel.
- s_axi_rvalid/rready/rdata/rresp/rid/rlast  out/in/out/out/out/out  1/1/DATA_WIDTH/2/ID_WIDTH/1  R channel.
- The unused AW/AR attributes (lock, cache, prot, qos, region) are accepted and ignored.

Behaviour:
- Reset values:
  - all valid/ready outputs 0; bresp, rresp, bid, rid, rdata, rlast 0.
  - state IDLE; arbitration priority pointer = write.
  - memory contents are not reset.
- Word index:
  - index = addr[MEM_WORDS_LOG2+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
  - low address bits are ignored; size is ignored, and every beat advances by one word.
- Bursts:
  - FIXED: index is constant for all beats.
  - INCR: index+1 per beat, wrapping modulo 2^MEM_WORDS_LOG2.
  - WRAP and reserved (2'b10, 2'b11): response SLVERR, no write performed, read data 0; beat count and handshakes are unchanged.
- States:
  - IDLE: awready = arready = 1 only in IDLE, and only for the channel granted this cycle.
  - AW and AR valid together: grant the channel the priority pointer names, then flip the pointer.
  - A lone valid is granted regardless of the pointer.
  - An AW handshake latches id/addr/len/burst and moves to WDATA.
  - An AR handshake latches the same fields, loads the latency counter = READ_LATENCY-1, and moves to RLAT.
- WDATA:
  - wready = 1; each handshake writes bytes where wstrb = 1.
  - A beat counter counts down from len.
  - On the beat where the counter = 0 → WRESP. wlast is not used for termination.
  - wlast mismatch (asserted early, or missing on the final beat) sets a sticky error; bresp = SLVERR for that burst.
- WRESP:
  - bvalid = 1, bid = latched id.
  - Hold until bready, then go to IDLE.
  - First bvalid appears the cycle after the last W handshake.
- RLAT: counter decrements once per cycle; at 0 → RDATA.
- RDATA:
  - Memory read is registered; rdata for beat n is stable while rvalid && !rready.
  - rvalid stays high across beats with no bubble if rready is held.
  - rid = latched id; rlast = 1 on the final beat.
  - Handshake on the final beat → IDLE.
  - Total cycles from AR handshake to first rvalid = READ_LATENCY.
- Boundary cases:
  - len = 0 gives a single beat.
  - len = 255 gives 256 beats.
  - Index wrap at the top of the array continues from 0.
  - rst asserted mid-burst aborts immediately; outputs return to reset values in the same cycle.

Optional Feature:
- Macro: EMU_AXI_RAM_OOB_ERR_EN.
- Defined:
  - Any beat whose full address is ≥ 2^(MEM_WORDS_LOG2) × DATA_WIDTH/8 returns DECERR.
  - Such a write beat is dropped; such a read beat returns 0 with rresp = DECERR.
  - bresp = DECERR if any beat was out of range; DECERR takes precedence over SLVERR.
  - INCR index increments without wrapping.
- Undefined: upper address bits are ignored and wrap modulo the array size applies. No DECERR is ever produced.

Test Plan:
- Single write then read back:
  - Stimulus: AW addr=0x100, len=0, INCR, id=3; W data=0x1122334455667788, strb=0xFF; then AR addr=0x100, id=5.
  - Response: B id=3 OKAY; R data=0x1122334455667788, rid=5, rlast=1; rvalid exactly READ_LATENCY=4 cycles after the AR handshake.
- Partial strobe:
  - Stimulus: write 0xFFFF...FF to addr 0x0, then write 0 with strb=0x0F.
  - Response: readback = 0xFFFFFFFF00000000.
- INCR 16 beats:
  - Stimulus: addr=0x200, len=15, data=beat index, rready toggling every other cycle.
  - Response: 16 beats returned in order 0..15; rlast only on beat 15; rdata held stable during stalls.
- Simultaneous AW and AR in IDLE after reset:
  - Response: write is granted first; on the next simultaneous request, read is granted.
- Error cases:
  - WRAP burst with len=3 → bresp = SLVERR; memory unchanged.
  - INCR len=3 with wlast on beat 1 → bresp = SLVERR.
- Reset and out-of-range:
  - Stimulus: rst pulsed during beat 5 of a len=7 read.
  - Response: rvalid drops asynchronously; next transaction proceeds normally.
  - With EMU_AXI_RAM_OOB_ERR_EN and MEM_WORDS_LOG2=16: a read of 0x80000 → rresp = DECERR, data 0.

Source files
------------

// File: rtl/emu_axi_ram_backend_if.sv
// ----------------------------------------------------------------------------
// emu_axi_ram_backend_if
//   AXI4 bus bundle between the emulated DUT's m_axi DRAM master and the
//   emu_axi_ram_backend memory model.
//
//   Channels carried (signal names drop the s_axi_ prefix of the instance):
//     AW : awvalid, awready, awaddr, awid, awlen, awsize, awburst
//     W  : wvalid, wready, wdata, wstrb, wlast
//     B  : bvalid, bready, bresp, bid
//     AR : arvalid, arready, araddr, arid, arlen, arsize, arburst
//     R  : rvalid, rready, rdata, rresp, rid, rlast
//   Modports: master (drives requests), slave (the memory model).
//   lock/cache/prot/qos/region are not carried; the slave ignores them.
// ----------------------------------------------------------------------------
interface emu_axi_ram_backend_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [ID_WIDTH-1:0]     awid;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic [ID_WIDTH-1:0]     bid;

    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [ID_WIDTH-1:0]     arid;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;

    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic [ID_WIDTH-1:0]     rid;
    logic                    rlast;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready
    );
endinterface

// File: rtl/emu_axi_ram_backend.sv
// ----------------------------------------------------------------------------
// emu_axi_ram_backend
//   AXI4 slave memory model placed directly behind the emulated DUT's m_axi
//   DRAM port. Serves one write or read burst at a time from an internal
//   word array; reads return their first beat READ_LATENCY cycles after the
//   AR handshake.
//
//   Ports:
//     clk   : single clock
//     rst   : asynchronous, active-high reset (memory contents are kept)
//     s_axi : emu_axi_ram_backend_if.slave (AW/W/B/AR/R channels)
//
//   Addressing: word index = addr[MEM_WORDS_LOG2+OFF-1:OFF], OFF =
//   log2(DATA_WIDTH/8). awsize/arsize are ignored; every beat is one word.
//   FIXED and INCR bursts are served; WRAP/reserved bursts complete their
//   handshakes but write nothing, read 0 and respond SLVERR.
//
//   Optional feature, macro EMU_AXI_RAM_OOB_ERR_EN:
//     defined   - beats addressing beyond the array return DECERR (writes
//                 dropped, reads 0); INCR does not wrap; DECERR wins over
//                 SLVERR in bresp.
//     undefined - upper address bits are ignored and the index wraps.
// ----------------------------------------------------------------------------
module emu_axi_ram_backend #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 4,
    parameter int MEM_WORDS_LOG2 = 16,
    parameter int READ_LATENCY   = 4
) (
    input logic                   clk,
    input logic                   rst,
    emu_axi_ram_backend_if.slave  s_axi
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int DEPTH  = 1 << MEM_WORDS_LOG2;
`ifdef EMU_AXI_RAM_OOB_ERR_EN
    // Keep the full word address so out-of-range beats can be detected.
    localparam int PTR_W  = ADDR_WIDTH - OFF;
`else
    localparam int PTR_W  = MEM_WORDS_LOG2;
`endif

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RLAT, RDATA} state_t;

    state_t                  state;
    logic                    prio_wr;     // 1: write wins the next AW/AR tie
    logic [ID_WIDTH-1:0]     id_q;
    logic [PTR_W-1:0]        ptr_q;
    logic [7:0]              cnt_q;       // beats remaining after the current one
    logic [7:0]              lat_q;
    logic [1:0]              burst_q;
    logic                    burst_err_q; // WRAP or reserved burst type
    logic                    slv_err_q;
    logic                    dec_err_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    grant_aw;
    logic                    grant_ar;
    logic [PTR_W-1:0]        ptr_nxt;
    logic                    cur_oob;
    logic                    nxt_oob;
    logic                    w_hs;
    logic                    w_final;
    logic                    w_slv_nxt;
    logic                    w_dec_nxt;
    logic                    mem_we;

    function automatic logic [1:0] beat_resp(input logic berr, input logic oob);
        if (oob)
            return RESP_DECERR;
        if (berr)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_word(
        input logic [MEM_WORDS_LOG2-1:0] idx, input logic berr, input logic oob);
        if (berr || oob)
            return '0;
        return mem[idx];
    endfunction

    // A tie goes to the channel the pointer names; a lone request always wins.
    assign grant_aw = s_axi.awvalid && (!s_axi.arvalid || prio_wr);
    assign grant_ar = s_axi.arvalid && (!s_axi.awvalid || !prio_wr);

    assign s_axi.awready = (state == IDLE) && grant_aw;
    assign s_axi.arready = (state == IDLE) && grant_ar;
    assign s_axi.wready  = (state == WDATA);
    assign s_axi.bvalid  = (state == WRESP);
    assign s_axi.rvalid  = (state == RDATA);

    assign ptr_nxt = (burst_q == BURST_INCR) ? ptr_q + PTR_W'(1) : ptr_q;

`ifdef EMU_AXI_RAM_OOB_ERR_EN
    assign cur_oob = |ptr_q[PTR_W-1:MEM_WORDS_LOG2];
    assign nxt_oob = |ptr_nxt[PTR_W-1:MEM_WORDS_LOG2];
`else
    assign cur_oob = 1'b0;
    assign nxt_oob = 1'b0;
`endif

    // wlast only feeds error detection; the beat counter ends the burst.
    assign w_hs      = (state == WDATA) && s_axi.wvalid;
    assign w_final   = (cnt_q == 8'd0);
    assign w_slv_nxt = slv_err_q | burst_err_q | (s_axi.wlast != w_final);
    assign w_dec_nxt = dec_err_q | cur_oob;
    assign mem_we    = w_hs && !burst_err_q && !cur_oob;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.wstrb[b])
                    mem[ptr_q[MEM_WORDS_LOG2-1:0]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prio_wr     <= 1'b1;
            id_q        <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
            burst_q     <= '0;
            burst_err_q <= 1'b0;
            slv_err_q   <= 1'b0;
            dec_err_q   <= 1'b0;
            s_axi.bresp <= '0;
            s_axi.bid   <= '0;
            s_axi.rresp <= '0;
            s_axi.rid   <= '0;
            s_axi.rdata <= '0;
            s_axi.rlast <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi.awvalid && s_axi.arvalid)
                        prio_wr <= ~prio_wr;
                    if (grant_aw) begin
                        id_q        <= s_axi.awid;
                        ptr_q       <= s_axi.awaddr[OFF +: PTR_W];
                        cnt_q       <= s_axi.awlen;
                        burst_q     <= s_axi.awburst;
                        burst_err_q <= (s_axi.awburst != BURST_FIXED) &&
                                       (s_axi.awburst != BURST_INCR);
                        slv_err_q   <= 1'b0;
                        dec_err_q   <= 1'b0;
                        state       <= WDATA;
                    end else if (grant_ar) begin
                        id_q        <= s_axi.arid;
                        ptr_q       <= s_axi.araddr[OFF +: PTR_W];
                        cnt_q       <= s_axi.arlen;
                        burst_q     <= s_axi.arburst;
                        burst_err_q <= (s_axi.arburst != BURST_FIXED) &&
                                       (s_axi.arburst != BURST_INCR);
                        lat_q       <= 8'(READ_LATENCY - 1);
                        state       <= RLAT;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        slv_err_q <= w_slv_nxt;
                        dec_err_q <= w_dec_nxt;
                        ptr_q     <= ptr_nxt;
                        cnt_q     <= cnt_q - 8'd1;
                        if (w_final) begin
                            s_axi.bid   <= id_q;
                            s_axi.bresp <= w_dec_nxt ? RESP_DECERR :
                                           (w_slv_nxt ? RESP_SLVERR : RESP_OKAY);
                            state       <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (s_axi.bready)
                        state <= IDLE;
                end
                RLAT: begin
                    // Counter starts at READ_LATENCY-1 so the first beat is
                    // registered exactly READ_LATENCY edges after AR.
                    if (lat_q == 8'd0) begin
                        s_axi.rdata <= read_word(ptr_q[MEM_WORDS_LOG2-1:0], burst_err_q, cur_oob);
                        s_axi.rresp <= beat_resp(burst_err_q, cur_oob);
                        s_axi.rlast <= (cnt_q == 8'd0);
                        s_axi.rid   <= id_q;
                        state       <= RDATA;
                    end else begin
                        lat_q <= lat_q - 8'd1;
                    end
                end
                RDATA: begin
                    if (s_axi.rready) begin
                        if (cnt_q == 8'd0) begin
                            s_axi.rdata <= '0;
                            s_axi.rresp <= RESP_OKAY;
                            s_axi.rlast <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            // Prefetch the next beat so rvalid has no bubble.
                            ptr_q       <= ptr_nxt;
                            cnt_q       <= cnt_q - 8'd1;
                            s_axi.rdata <= read_word(ptr_nxt[MEM_WORDS_LOG2-1:0], burst_err_q, nxt_oob);
                            s_axi.rresp <= beat_resp(burst_err_q, nxt_oob);
                            s_axi.rlast <= (cnt_q == 8'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address low bits, upper bits (default build) and sizes are not used.
    logic unused_bits;
    assign unused_bits = ^{s_axi.awsize, s_axi.arsize, s_axi.awaddr, s_axi.araddr};

endmodule

// File: tb/tb_emu_axi_ram_backend.sv
module tb_emu_axi_ram_backend;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int IW  = 4;
    localparam int MWL = 16;
    localparam int RL  = 4;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    emu_axi_ram_backend_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    emu_axi_ram_backend #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .MEM_WORDS_LOG2(MWL), .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axi(bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    logic [63:0] exp_data [0:255];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        int n;
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len;
        bus.awburst = burst; bus.awid = id; bus.awsize = 3'd3;
        #1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 50) begin tick(); n++; end
        check("aw_ready", 64'(bus.awready), 64'(1));
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        int n;
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len;
        bus.arburst = burst; bus.arid = id; bus.arsize = 3'd3;
        #1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 50) begin tick(); n++; end
        check("ar_ready", 64'(bus.arready), 64'(1));
        tick();
        bus.arvalid = 1'b0;
    endtask

    // Beats come from exp_data; wlast is raised only on beat last_at.
    task automatic send_w(input int nbeats, input logic [7:0] strb, input int last_at);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            bus.wvalid = 1'b1; bus.wdata = exp_data[i];
            bus.wstrb = strb; bus.wlast = (i == last_at);
            #1;
            n = 0;
            while (bus.wready !== 1'b1 && n < 50) begin tick(); n++; end
            check("w_ready", 64'(bus.wready), 64'(1));
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic get_b(input logic [3:0] id, input logic [1:0] resp);
        int n;
        bus.bready = 1'b1;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 50) begin tick(); n++; end
        check("b_valid", 64'(bus.bvalid), 64'(1));
        check("b_id", 64'(bus.bid), 64'(id));
        check("b_resp", 64'(bus.bresp), 64'(resp));
        tick();
        bus.bready = 1'b0;
        check("b_valid_drop", 64'(bus.bvalid), 64'(0));
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 600) begin tick(); n++; end
    endtask

    // Expects beats exp_data[0..nbeats-1]; toggle stalls every other cycle.
    task automatic recv_r(input int nbeats, input logic [3:0] id,
                          input logic [1:0] resp, input bit toggle);
        int beat;
        int cyc;
        bit stalled;
        logic [63:0] held;
        beat = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (beat < nbeats && cyc < 2000) begin
            bus.rready = toggle ? (cyc % 2 == 1) : 1'b1;
            check("r_valid", 64'(bus.rvalid), 64'(1));
            if (stalled)
                check("r_stall_stable", bus.rdata, held);
            if (bus.rready) begin
                check("r_data", bus.rdata, exp_data[beat]);
                check("r_last", 64'(bus.rlast), 64'(beat == nbeats - 1));
                check("r_id", 64'(bus.rid), 64'(id));
                check("r_resp", 64'(bus.rresp), 64'(resp));
                beat++;
                stalled = 1'b0;
            end else begin
                held = bus.rdata;
                stalled = 1'b1;
            end
            tick();
            cyc++;
        end
        bus.rready = 1'b0;
        check("r_beats", 64'(beat), 64'(nbeats));
        check("r_valid_drop", 64'(bus.rvalid), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;

        // Reset state
        repeat (3) tick();
        check("rst_rvalid", 64'(bus.rvalid), 64'(0));
        check("rst_bvalid", 64'(bus.bvalid), 64'(0));
        check("rst_wready", 64'(bus.wready), 64'(0));
        check("rst_rdata", bus.rdata, 64'(0));
        check("rst_rlast", 64'(bus.rlast), 64'(0));
        check("rst_bresp", 64'(bus.bresp), 64'(0));
        rst = 1'b0;
        tick();
        bus.awvalid = 1'b1;
        #1;
        check("idle_awready_lone", 64'(bus.awready), 64'(1));
        bus.awvalid = 1'b0;
        #1;
        check("idle_awready_none", 64'(bus.awready), 64'(0));
        tick();

        // Single write then read back with latency check
        send_aw(32'h100, 8'd0, INCR, 4'd3);
        exp_data[0] = 64'h1122334455667788;
        send_w(1, 8'hFF, 0);
        check("b_next_cycle", 64'(bus.bvalid), 64'(1));
        get_b(4'd3, OKAY);
        send_ar(32'h100, 8'd0, INCR, 4'd5);
        wait_rvalid(n);
        check("r_latency", 64'(n), 64'(RL));
        recv_r(1, 4'd5, OKAY, 1'b0);

        // Simultaneous AW/AR: write first, then read
        bus.awvalid = 1'b1; bus.awaddr = 32'h300; bus.awlen = 0; bus.awburst = INCR; bus.awid = 4'd1;
        bus.arvalid = 1'b1; bus.araddr = 32'h300; bus.arlen = 0; bus.arburst = INCR; bus.arid = 4'd2;
        #1;
        check("tie1_awready", 64'(bus.awready), 64'(1));
        check("tie1_arready", 64'(bus.arready), 64'(0));
        tick();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        exp_data[0] = 64'hA5A5A5A5_5A5A5A5A;
        send_w(1, 8'hFF, 0);
        get_b(4'd1, OKAY);
        bus.awvalid = 1'b1; bus.awaddr = 32'h308;
        bus.arvalid = 1'b1;
        #1;
        check("tie2_awready", 64'(bus.awready), 64'(0));
        check("tie2_arready", 64'(bus.arready), 64'(1));
        tick();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        wait_rvalid(n);
        check("tie2_latency", 64'(n), 64'(RL));
        recv_r(1, 4'd2, OKAY, 1'b0);

        // Partial strobe
        send_aw(32'h0, 8'd0, INCR, 4'd0);
        exp_data[0] = 64'hFFFFFFFF_FFFFFFFF;
        send_w(1, 8'hFF, 0);
        get_b(4'd0, OKAY);
        send_aw(32'h0, 8'd0, INCR, 4'd0);
        exp_data[0] = 64'h0;
        send_w(1, 8'h0F, 0);
        get_b(4'd0, OKAY);
        send_ar(32'h0, 8'd0, INCR, 4'd1);
        exp_data[0] = 64'hFFFFFFFF_00000000;
        wait_rvalid(n);
        recv_r(1, 4'd1, OKAY, 1'b0);

        // INCR 16 beats, rready toggling
        for (int i = 0; i < 16; i++) exp_data[i] = 64'(i);
        send_aw(32'h200, 8'd15, INCR, 4'd4);
        send_w(16, 8'hFF, 15);
        get_b(4'd4, OKAY);
        send_ar(32'h200, 8'd15, INCR, 4'd6);
        wait_rvalid(n);
        check("incr16_latency", 64'(n), 64'(RL));
        recv_r(16, 4'd6, OKAY, 1'b1);

        // WRAP burst: SLVERR, memory untouched, read data 0
        for (int i = 0; i < 4; i++) exp_data[i] = 64'hDEAD0000 + 64'(i);
        send_aw(32'h200, 8'd3, WRAP, 4'd4);
        send_w(4, 8'hFF, 3);
        get_b(4'd4, SLVERR);
        for (int i = 0; i < 4; i++) exp_data[i] = 64'(i);
        send_ar(32'h200, 8'd3, INCR, 4'd7);
        wait_rvalid(n);
        recv_r(4, 4'd7, OKAY, 1'b0);
        for (int i = 0; i < 2; i++) exp_data[i] = 64'h0;
        send_ar(32'h200, 8'd1, WRAP, 4'd8);
        wait_rvalid(n);
        recv_r(2, 4'd8, SLVERR, 1'b0);

        // Early wlast: SLVERR
        send_aw(32'h400, 8'd3, INCR, 4'd9);
        send_w(4, 8'hFF, 1);
        get_b(4'd9, SLVERR);

        // FIXED burst keeps the last beat; error flags clear for a new burst
        exp_data[0] = 64'h1; exp_data[1] = 64'h2; exp_data[2] = 64'h3;
        send_aw(32'h500, 8'd2, FIXED, 4'd2);
        send_w(3, 8'hFF, 2);
        get_b(4'd2, OKAY);
        exp_data[0] = 64'h3;
        send_ar(32'h500, 8'd0, INCR, 4'd2);
        wait_rvalid(n);
        recv_r(1, 4'd2, OKAY, 1'b0);

        // Top-of-array index behaviour
        exp_data[0] = 64'h1111; exp_data[1] = 64'h2222;
        send_aw(32'h7FFF8, 8'd1, INCR, 4'd1);
        send_w(2, 8'hFF, 1);
`ifdef EMU_AXI_RAM_OOB_ERR_EN
        get_b(4'd1, DECERR);
        exp_data[0] = 64'h0;
        send_ar(32'h80000, 8'd0, INCR, 4'd3);
        wait_rvalid(n);
        recv_r(1, 4'd3, DECERR, 1'b0);
`else
        get_b(4'd1, OKAY);
        exp_data[0] = 64'h2222;
        send_ar(32'h0, 8'd0, INCR, 4'd3);
        wait_rvalid(n);
        recv_r(1, 4'd3, OKAY, 1'b0);
        exp_data[0] = 64'h1111; exp_data[1] = 64'h2222;
        send_ar(32'h7FFF8, 8'd1, INCR, 4'd3);
        wait_rvalid(n);
        recv_r(2, 4'd3, OKAY, 1'b0);
`endif

        // len = 255: 256 beats, back-to-back
        for (int i = 0; i < 256; i++) exp_data[i] = 64'hC0DE0000 + 64'(i);
        send_aw(32'h1000, 8'd255, INCR, 4'd7);
        send_w(256, 8'hFF, 255);
        get_b(4'd7, OKAY);
        send_ar(32'h1000, 8'd255, INCR, 4'd7);
        wait_rvalid(n);
        recv_r(256, 4'd7, OKAY, 1'b0);

        // Reset during beat 5 of a len=7 read
        for (int i = 0; i < 8; i++) exp_data[i] = 64'(i);
        send_aw(32'h200, 8'd7, INCR, 4'd4);
        send_w(8, 8'hFF, 7);
        get_b(4'd4, OKAY);
        send_ar(32'h200, 8'd7, INCR, 4'd6);
        wait_rvalid(n);
        bus.rready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("mid_data", bus.rdata, exp_data[i]);
            tick();
        end
        check("mid_beat5", bus.rdata, 64'h5);
        check("mid_rvalid", 64'(bus.rvalid), 64'(1));
        rst = 1'b1;
        #1;
        check("async_rvalid", 64'(bus.rvalid), 64'(0));
        check("async_rdata", bus.rdata, 64'(0));
        check("async_rlast", 64'(bus.rlast), 64'(0));
        check("async_rid", 64'(bus.rid), 64'(0));
        bus.rready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        exp_data[0] = 64'h1122334455667788;
        send_ar(32'h100, 8'd0, INCR, 4'd5);
        wait_rvalid(n);
        check("post_rst_latency", 64'(n), 64'(RL));
        recv_r(1, 4'd5, OKAY, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
